// File: rtl/decompress_stream_sched.sv
// Block-level image decompression scheduler: spreads raster-order coefficient blocks over
// NUM_CORES reconstruction cores and retires the results strictly in input order.

module decompress_block #(
  parameter int unsigned BLOCK_SIZE  = 8,
  parameter int unsigned COEFF_WIDTH = 9,
  parameter int unsigned OUT_WIDTH   = 63
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 start_block,
  input  logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][COEFF_WIDTH-1:0] block_in,
  output logic                                                 block_done,
  output logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][OUT_WIDTH-1:0]   reconstructed_block_out
);
  localparam int unsigned CNT_W = $clog2(BLOCK_SIZE + 4) + 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] last_cnt;

  // Latency depends on the DC coefficient's low bits, so cores may finish out of order.
  assign last_cnt   = CNT_W'(BLOCK_SIZE - 1) + CNT_W'(block_in[0][0][1:0]);
  assign block_done = start_block && (cnt_q == last_cnt);

  always_ff @(posedge clk) begin
    if (!rst_n || !start_block) cnt_q <= '0;
    else if (!block_done)       cnt_q <= cnt_q + CNT_W'(1);
  end

  // Dequantize each coefficient with a step of (row + col + 1).
  for (genvar r = 0; r < BLOCK_SIZE; r++) begin : g_row
    for (genvar c = 0; c < BLOCK_SIZE; c++) begin : g_col
      localparam logic signed [OUT_WIDTH-1:0] STEP = OUT_WIDTH'(r + c + 1);
      logic signed [OUT_WIDTH-1:0] coeff;
      assign coeff = OUT_WIDTH'($signed(block_in[r][c]));
      assign reconstructed_block_out[r][c] = coeff * STEP;
    end
  end
endmodule

module decompress_stream_sched #(
  parameter int unsigned IMG_ROWS          = 480,
  parameter int unsigned IMG_COLS          = 640,
  parameter int unsigned BLOCK_SIZE        = 8,
  parameter int unsigned LOG2_BLOCK_SIZE   = 3,
  parameter int unsigned COEFF_WIDTH       = 9,
  parameter int unsigned RECONST_OUT_WIDTH = 54,
  parameter int unsigned NUM_CORES         = 4,
  localparam int unsigned OUT_W    = RECONST_OUT_WIDTH + 9,
  localparam int unsigned BLK_ROWS = IMG_ROWS >> LOG2_BLOCK_SIZE,
  localparam int unsigned BLK_COLS = IMG_COLS >> LOG2_BLOCK_SIZE,
  localparam int unsigned ROW_W    = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1,
  localparam int unsigned COL_W    = (BLK_COLS > 1) ? $clog2(BLK_COLS) : 1
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   start_img,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][COEFF_WIDTH-1:0] in_block,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][OUT_W-1:0]       out_block,
  output logic [ROW_W-1:0]                                       out_blk_row,
  output logic [COL_W-1:0]                                       out_blk_col,
  output logic                                                   out_last,
  output logic                                                   img_done,
  output logic                                                   busy
);
  localparam int unsigned N_BLK = BLK_ROWS * BLK_COLS;
  localparam int unsigned CNT_W = $clog2(N_BLK + 1);
  localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  typedef enum logic [1:0] {SL_FREE = 2'd0, SL_RUN = 2'd1, SL_HOLD = 2'd2} slot_t;
  typedef logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][COEFF_WIDTH-1:0] coeff_blk_t;
  typedef logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][OUT_W-1:0]       recon_blk_t;

  state_t           state_q, state_d;
  slot_t            slot_q  [NUM_CORES];
  coeff_blk_t       in_reg  [NUM_CORES];
  recon_blk_t       res_reg [NUM_CORES];
  recon_blk_t       core_out[NUM_CORES];
  logic [NUM_CORES-1:0] core_done;

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_n;
  logic [CNT_W-1:0] acc_cnt_q, ret_cnt_q;
  logic [ROW_W-1:0] ret_row_q;
  logic [COL_W-1:0] ret_col_q;
  logic             accept, fire, load, start_go;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_CORES - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready = (state_q == S_RUN) && (slot_q[wr_ptr_q] == SL_FREE) &&
                    (acc_cnt_q < CNT_W'(N_BLK));
  assign accept   = in_valid && in_ready;
  assign fire     = out_valid && out_ready;
  assign start_go = (state_q == S_IDLE) && start_img;

  // Top-level image FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_img) state_d = S_RUN;
      S_RUN:   if (fire && out_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output register reloads when empty or draining, from the next in-order slot if it is ready.
  // With one core the freed slot is the same slot, so it must not be reloaded on that edge.
  always_comb begin
    rd_ptr_n = fire ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    load     = (state_q == S_RUN) && (!out_valid || fire) &&
               (slot_q[rd_ptr_n] == SL_HOLD) && !(fire && (rd_ptr_n == rd_ptr_q));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      acc_cnt_q   <= '0;
      ret_cnt_q   <= '0;
      ret_row_q   <= '0;
      ret_col_q   <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_block   <= '0;
      out_blk_row <= '0;
      out_blk_col <= '0;
      img_done    <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) slot_q[i] <= SL_FREE;
    end else begin
      state_q  <= state_d;
      busy     <= (state_d != S_IDLE);
      img_done <= fire && out_last;

      if (start_go) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        acc_cnt_q <= '0;
        ret_cnt_q <= '0;
        ret_row_q <= '0;
        ret_col_q <= '0;
      end else begin
        if (accept) begin
          wr_ptr_q  <= ptr_inc(wr_ptr_q);
          acc_cnt_q <= acc_cnt_q + CNT_W'(1);
        end
        if (fire) rd_ptr_q <= rd_ptr_n;
        if (load) begin
          out_valid   <= 1'b1;
          out_block   <= res_reg[rd_ptr_n];
          out_blk_row <= ret_row_q;
          out_blk_col <= ret_col_q;
          out_last    <= (ret_cnt_q == CNT_W'(N_BLK - 1));
          if (ret_cnt_q < CNT_W'(N_BLK)) ret_cnt_q <= ret_cnt_q + CNT_W'(1);
          if (ret_cnt_q < CNT_W'(N_BLK - 1)) begin
            if (ret_col_q == COL_W'(BLK_COLS - 1)) begin
              ret_col_q <= '0;
              ret_row_q <= ret_row_q + ROW_W'(1);
            end else begin
              ret_col_q <= ret_col_q + COL_W'(1);
            end
          end
        end else if (fire) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end

      // Slot lifecycle: FREE -> RUN on accept, RUN -> HOLD on core done, HOLD -> FREE on retire.
      for (int i = 0; i < NUM_CORES; i++) begin
        if (slot_q[i] == SL_FREE && accept && wr_ptr_q == PTR_W'(i))
          slot_q[i] <= SL_RUN;
        else if (slot_q[i] == SL_RUN && core_done[i])
          slot_q[i] <= SL_HOLD;
        else if (slot_q[i] == SL_HOLD && fire && rd_ptr_q == PTR_W'(i))
          slot_q[i] <= SL_FREE;
      end
    end
  end

  // Payload registers carry no reset; slot state alone qualifies them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (accept && wr_ptr_q == PTR_W'(i)) in_reg[i] <= in_block;
      if (slot_q[i] == SL_RUN && core_done[i]) res_reg[i] <= core_out[i];
    end
  end

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    decompress_block #(
      .BLOCK_SIZE (BLOCK_SIZE),
      .COEFF_WIDTH(COEFF_WIDTH),
      .OUT_WIDTH  (OUT_W)
    ) u_core (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .start_block            (slot_q[i] == SL_RUN),
      .block_in               (in_reg[i]),
      .block_done             (core_done[i]),
      .reconstructed_block_out(core_out[i])
    );
  end
endmodule

// File: tb/tb_decompress_stream_sched.sv
// Bench for decompress_stream_sched on a 16x16 image (four blocks) with two cores; outputs are
// checked against an in-order reference queue built from every accepted coefficient block.

module tb_decompress_stream_sched;
  localparam int BS      = 8;
  localparam int CW      = 9;
  localparam int OW      = 54 + 9;
  localparam int N_BLK   = 4;
  localparam int BCOLS   = 2;
  localparam int RW      = 1;
  localparam int CLW     = 1;
  localparam int TIMEOUT = 400;

  typedef logic [BS-1:0][BS-1:0][CW-1:0] cblk_t;
  typedef logic [BS-1:0][BS-1:0][OW-1:0] rblk_t;
  typedef struct {
    rblk_t          blk;
    logic [RW-1:0]  row;
    logic [CLW-1:0] col;
    logic           last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, start_img, in_valid, in_ready, out_valid, out_ready;
  logic           out_last, img_done, busy;
  cblk_t          in_block;
  rblk_t          out_block;
  logic [RW-1:0]  out_blk_row;
  logic [CLW-1:0] out_blk_col;

  decompress_stream_sched #(
    .IMG_ROWS(16), .IMG_COLS(16), .BLOCK_SIZE(8), .LOG2_BLOCK_SIZE(3),
    .COEFF_WIDTH(9), .RECONST_OUT_WIDTH(54), .NUM_CORES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_img(start_img),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .out_blk_row(out_blk_row), .out_blk_col(out_blk_col),
    .out_last(out_last), .img_done(img_done), .busy(busy)
  );

  int    errors = 0;
  int    checks = 0;
  exp_t  exp_q[$];
  int    acc_idx = 0;
  int    hs_idx = 0;
  int    done_cnt = 0;
  int    hs_row[4];
  int    hs_col[4];
  rblk_t last_hs_blk;
  logic  prev_fire_last = 1'b0;
  int    fi, fj;
  exp_t  e;
  int    lit_row[4] = '{0, 0, 1, 1};
  int    lit_col[4] = '{0, 1, 0, 1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: each coefficient scaled by (row+col+1); coordinates follow raster acceptance order.
  function automatic rblk_t recon(input cblk_t b);
    rblk_t r;
    longint v;
    for (int i = 0; i < BS; i++)
      for (int j = 0; j < BS; j++) begin
        v = longint'($signed(b[i][j])) * longint'(i + j + 1);
        r[i][j] = v[OW-1:0];
      end
    return r;
  endfunction

  function automatic cblk_t rand_blk();
    cblk_t b;
    for (int i = 0; i < BS; i++)
      for (int j = 0; j < BS; j++) b[i][j] = CW'($urandom_range(0, 511));
    return b;
  endfunction

  // Single compare process: retire checks first, then record newly accepted inputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_idx = 0;
      hs_idx = 0;
      prev_fire_last = 1'b0;
    end else begin
      chk("img_done_pulse", 64'(img_done), 64'(prev_fire_last));
      if (img_done) done_cnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q[0];
          fi = -1; fj = -1;
          for (int i = 0; i < BS; i++)
            for (int j = 0; j < BS; j++)
              if (fi < 0 && out_block[i][j] !== e.blk[i][j]) begin fi = i; fj = j; end
          checks++;
          if (fi >= 0 || out_blk_row !== e.row || out_blk_col !== e.col || out_last !== e.last) begin
            errors++;
            if (fi < 0) begin fi = 0; fj = 0; end
            $display("FAIL out_payload: got row=%0d col=%0d last=%0d blk[%0d][%0d]=%0h expected row=%0d col=%0d last=%0d blk=%0h",
                     out_blk_row, out_blk_col, out_last, fi, fj, out_block[fi][fj],
                     e.row, e.col, e.last, e.blk[fi][fj]);
          end
          if (out_ready) begin
            if (hs_idx < 4) begin
              hs_row[hs_idx] = int'(out_blk_row);
              hs_col[hs_idx] = int'(out_blk_col);
            end
            hs_idx++;
            last_hs_blk = out_block;
            void'(exp_q.pop_front());
          end
        end
      end
      prev_fire_last = out_valid && out_ready && out_last;
      if (start_img && !busy) begin
        acc_idx = 0;
        hs_idx = 0;
      end
      if (in_valid && in_ready) begin
        e.blk  = recon(in_block);
        e.row  = RW'(acc_idx / BCOLS);
        e.col  = CLW'(acc_idx % BCOLS);
        e.last = (acc_idx == N_BLK - 1);
        exp_q.push_back(e);
        acc_idx++;
      end
    end
  end

  task automatic start_image();
    start_img = 1'b1;
    @(posedge clk); #1;
    start_img = 1'b0;
  endtask

  task automatic send_block(input cblk_t b);
    int n = 0;
    in_block = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < TIMEOUT) begin @(negedge clk); n++; end
    chk("in_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_image(input string name);
    int n = 0;
    @(negedge clk);
    while (!img_done && n < TIMEOUT) begin @(negedge clk); n++; end
    chk({name, "_img_done"}, 64'(img_done), 64'd1);
  endtask

  task automatic check_coords(input string name);
    chk({name, "_count"}, 64'(hs_idx), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk({name, "_row"}, 64'(hs_row[k]), 64'(lit_row[k]));
      chk({name, "_col"}, 64'(hs_col[k]), 64'(lit_col[k]));
    end
    chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cblk_t        blk_a, blk_b;
    int           d0;
    logic [OW-1:0] lit_neg12;
    rst_n = 1'b0; start_img = 1'b0; in_valid = 1'b0; in_block = '0; out_ready = 1'b0;

    // Reset for two edges, then idle with no start.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'd0);
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
    end
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_block_zero", 64'(out_block == '0), 64'd1);
    @(posedge clk); #1;

    // Image of four all-zero blocks with the sink always ready.
    out_ready = 1'b1;
    d0 = done_cnt;
    start_image();
    chk("run_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 4; k++) send_block('0);
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    wait_image("img1");
    @(negedge clk);
    chk("img1_idle_busy", 64'(busy), 64'd0);
    chk("img1_done_once", 64'(done_cnt - d0), 64'd1);
    chk("img1_zero_blk", 64'(last_hs_blk == '0), 64'd1);
    check_coords("img1");
    @(posedge clk); #1;

    // Two blocks occupy both cores; the third stalls until the first retires.
    blk_a = '0; blk_a[0][0] = 9'd3; blk_a[1][2] = 9'h1FD; blk_a[7][7] = 9'd2;
    blk_b = '0; blk_b[0][0] = 9'd4; blk_b[3][3] = 9'h1FF;
    out_ready = 1'b0;
    start_image();
    send_block(blk_a);
    send_block(blk_b);
    in_block = rand_blk();
    in_valid = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("hs_cycle_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("freed_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    lit_neg12 = OW'(-12);
    chk("lit_a00", 64'(last_hs_blk[0][0]), 64'd3);
    chk("lit_a12", 64'(last_hs_blk[1][2]), 64'(lit_neg12));
    chk("lit_a77", 64'(last_hs_blk[7][7]), 64'd30);
    chk("lit_a01", 64'(last_hs_blk[0][1]), 64'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    send_block(rand_blk());
    wait_image("img2");
    check_coords("img2");
    @(posedge clk); #1;

    // Sink toggles every cycle while four random blocks stream in.
    start_image();
    fork
      begin
        for (int k = 0; k < 4; k++) send_block(rand_blk());
      end
      begin
        int n = 0;
        while (!img_done && n < TIMEOUT) begin @(posedge clk); #1 out_ready = ~out_ready; n++; end
      end
    join
    chk("toggle_img_done", 64'(img_done), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_coords("img3");
    @(posedge clk); #1;

    // Reset with two blocks in flight, then a clean image.
    start_image();
    send_block(rand_blk());
    send_block(rand_blk());
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    start_image();
    for (int k = 0; k < 4; k++) send_block(rand_blk());
    wait_image("img4");
    @(negedge clk);
    check_coords("img4");
    @(posedge clk); #1;

    // start_img pulses during RUN and DONE are ignored.
    d0 = done_cnt;
    start_image();
    send_block(rand_blk());
    start_image();
    send_block(rand_blk());
    start_image();
    send_block(rand_blk());
    send_block(rand_blk());
    wait_image("img5");
    start_img = 1'b1;
    @(posedge clk); #1 start_img = 1'b0;
    @(negedge clk);
    chk("done_start_busy", 64'(busy), 64'd0);
    chk("done_start_in_ready", 64'(in_ready), 64'd0);
    check_coords("img5");
    chk("img5_done_once", 64'(done_cnt - d0), 64'd1);
    repeat (5) @(negedge clk);
    chk("final_busy", 64'(busy), 64'd0);
    chk("final_out_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
